// File: rtl/serializer16_pkg.sv
// Shared types and widths for the 16-bit serializer.
// PARITY state exists only when SERIALIZER16_PARITY_EN is defined.
package serializer16_pkg;

    localparam int WORD_W = 16;
    localparam int SEL_W  = 4;

`ifdef SERIALIZER16_PARITY_EN
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        SHIFT
    } state_t;
`endif

endpackage

// File: rtl/mux16_1.sv
// 16:1 bit select.
// Latency: combinational, zero cycles.
// Backpressure: none, pure datapath.
module mux16_1 (
    input  logic [15:0] in,
    input  logic [3:0]  select,
    output logic        y
);

    assign y = in[select];

endmodule

// File: rtl/serializer16.sv
// 16-bit parallel-to-serial converter, LSB or MSB first; optional even-parity beat (SERIALIZER16_PARITY_EN).
// Latency: first beat the cycle after accept; 16 (17) beats per word plus one idle cycle between words.
// Backpressure: ser_ready low freezes sel/ser_data/state; in_ready is high only in IDLE.
module serializer16
    import serializer16_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_W-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 ser_data,
    output logic                 ser_valid,
    input  logic                 ser_ready,
    output logic                 ser_last,
    output logic [SEL_W-1:0]     sel
);

    localparam logic [SEL_W-1:0] SEL_FIRST = MSB_FIRST ? 4'd15 : 4'd0;
    localparam logic [SEL_W-1:0] SEL_FINAL = MSB_FIRST ? 4'd0  : 4'd15;

    state_t             state;
    logic [WORD_W-1:0]  hold;
    logic               mux_y;
    logic               accept;
    logic               beat;
    logic               at_final;
    logic [SEL_W-1:0]   sel_next;

    assign accept   = in_valid && in_ready;
    assign beat     = ser_valid && ser_ready;
    assign at_final = (sel == SEL_FINAL);
    assign sel_next = MSB_FIRST ? (sel - 4'd1) : (sel + 4'd1);

    mux16_1 u_mux (
        .in     (hold),
        .select (sel),
        .y      (mux_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            hold      <= '0;
            in_ready  <= 1'b1;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hold      <= in_data;
                        sel       <= SEL_FIRST;
                        state     <= SHIFT;
                        in_ready  <= 1'b0;
                        ser_valid <= 1'b1;
                        ser_last  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (beat) begin
                        if (at_final) begin
`ifdef SERIALIZER16_PARITY_EN
                            state     <= PARITY;
                            ser_last  <= 1'b1;
`else
                            state     <= IDLE;
                            in_ready  <= 1'b1;
                            ser_valid <= 1'b0;
                            ser_last  <= 1'b0;
`endif
                        end else begin
                            sel <= sel_next;
                            // ser_last is registered, so flag it one beat ahead
`ifdef SERIALIZER16_PARITY_EN
                            ser_last <= 1'b0;
`else
                            ser_last <= (sel_next == SEL_FINAL);
`endif
                        end
                    end
                end
`ifdef SERIALIZER16_PARITY_EN
                PARITY: begin
                    if (beat) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        ser_valid <= 1'b0;
                        ser_last  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    ser_valid <= 1'b0;
                    ser_last  <= 1'b0;
                end
            endcase
        end
    end

    // Idle drives 0 so the line is quiet between words
    always_comb begin
        ser_data = 1'b0;
        case (state)
            SHIFT:  ser_data = mux_y;
`ifdef SERIALIZER16_PARITY_EN
            PARITY: ser_data = ^hold;
`endif
            default: ser_data = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_serializer16.sv
// Directed bench for serializer16: LSB-first and MSB-first instances, backpressure, reset, back-to-back words.
module tb_serializer16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ser_ready = 1'b1;

    logic [15:0] in_data0 = 16'h0;
    logic        in_valid0 = 1'b0;
    logic        in_ready0, ser_data0, ser_valid0, ser_last0;
    logic [3:0]  sel0;

    logic [15:0] in_data1 = 16'h0;
    logic        in_valid1 = 1'b0;
    logic        in_ready1, ser_data1, ser_valid1, ser_last1;
    logic [3:0]  sel1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serializer16 #(.MSB_FIRST(1'b0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data0),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .ser_data  (ser_data0),
        .ser_valid (ser_valid0),
        .ser_ready (ser_ready),
        .ser_last  (ser_last0),
        .sel       (sel0)
    );

    serializer16 #(.MSB_FIRST(1'b1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .ser_data  (ser_data1),
        .ser_valid (ser_valid1),
        .ser_ready (ser_ready),
        .ser_last  (ser_last1),
        .sel       (sel1)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends w on dut0 and checks every beat; optional stall of stall_n cycles at sel==stall_sel
    task automatic run_word0(input logic [15:0] w, input logic exp_par, input int stall_sel,
                             input int stall_n, input logic hold_valid, input logic [15:0] next_w,
                             input string tag);
        logic exp_last;
        in_valid0 = 1'b1;
        in_data0  = w;
        check($sformatf("%s_in_ready_accept", tag), {15'h0, in_ready0}, 16'h1);
        tick();
        in_valid0 = hold_valid;
        in_data0  = hold_valid ? next_w : ~w;
        for (int i = 0; i < 16; i++) begin
            if (i == stall_sel) begin
                ser_ready = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    tick();
                    check($sformatf("%s_stall%0d_sel", tag, k), {12'h0, sel0}, i[15:0]);
                    check($sformatf("%s_stall%0d_data", tag, k), {15'h0, ser_data0}, {15'h0, w[i]});
                    check($sformatf("%s_stall%0d_valid", tag, k), {15'h0, ser_valid0}, 16'h1);
                end
                ser_ready = 1'b1;
            end
`ifdef SERIALIZER16_PARITY_EN
            exp_last = 1'b0;
`else
            exp_last = (i == 15);
`endif
            check($sformatf("%s_b%0d_valid", tag, i), {15'h0, ser_valid0}, 16'h1);
            check($sformatf("%s_b%0d_sel", tag, i), {12'h0, sel0}, i[15:0]);
            check($sformatf("%s_b%0d_data", tag, i), {15'h0, ser_data0}, {15'h0, w[i]});
            check($sformatf("%s_b%0d_last", tag, i), {15'h0, ser_last0}, {15'h0, exp_last});
            tick();
        end
`ifdef SERIALIZER16_PARITY_EN
        check($sformatf("%s_par_valid", tag), {15'h0, ser_valid0}, 16'h1);
        check($sformatf("%s_par_data", tag), {15'h0, ser_data0}, {15'h0, exp_par});
        check($sformatf("%s_par_last", tag), {15'h0, ser_last0}, 16'h1);
        tick();
`else
        exp_last = exp_par;
`endif
        check($sformatf("%s_end_in_ready", tag), {15'h0, in_ready0}, 16'h1);
        check($sformatf("%s_end_valid", tag), {15'h0, ser_valid0}, 16'h0);
        check($sformatf("%s_end_last", tag), {15'h0, ser_last0}, 16'h0);
    endtask

    initial begin
        logic exp_last1;
        rst = 1'b1;
        tick();
        tick();
        check("rst_in_ready", {15'h0, in_ready0}, 16'h1);
        check("rst_valid", {15'h0, ser_valid0}, 16'h0);
        check("rst_last", {15'h0, ser_last0}, 16'h0);
        check("rst_data", {15'h0, ser_data0}, 16'h0);
        check("rst_sel", {12'h0, sel0}, 16'h0);
        check("rst_m_sel", {12'h0, sel1}, 16'h0);
        rst = 1'b0;

        // LSB first: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
        run_word0(16'hA5C3, 1'b0, -1, 0, 1'b0, 16'h0, "a5c3");

        // MSB first on dut1: 1, fourteen 0s, 1; sel 15 down to 0
        in_valid1 = 1'b1;
        in_data1  = 16'h8001;
        check("msb_in_ready", {15'h0, in_ready1}, 16'h1);
        tick();
        in_valid1 = 1'b0;
        in_data1  = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
`ifdef SERIALIZER16_PARITY_EN
            exp_last1 = 1'b0;
`else
            exp_last1 = (i == 15);
`endif
            check($sformatf("msb_b%0d_sel", i), {12'h0, sel1}, 16'(15 - i));
            check($sformatf("msb_b%0d_data", i), {15'h0, ser_data1}, ((i == 0) || (i == 15)) ? 16'h1 : 16'h0);
            check($sformatf("msb_b%0d_valid", i), {15'h0, ser_valid1}, 16'h1);
            check($sformatf("msb_b%0d_last", i), {15'h0, ser_last1}, {15'h0, exp_last1});
            tick();
        end
`ifdef SERIALIZER16_PARITY_EN
        check("msb_par_data", {15'h0, ser_data1}, 16'h0);
        check("msb_par_last", {15'h0, ser_last1}, 16'h1);
        tick();
`endif
        check("msb_end_in_ready", {15'h0, in_ready1}, 16'h1);
        check("msb_end_valid", {15'h0, ser_valid1}, 16'h0);

        // Backpressure: 3-cycle stall at sel=5 (bit5=1, bit6=0)
        run_word0(16'h0020, 1'b1, 5, 3, 1'b0, 16'h0, "bp");

        // Reset mid-word at sel=7 of FFFF
        in_valid0 = 1'b1;
        in_data0  = 16'hFFFF;
        tick();
        in_valid0 = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("rmid_sel7", {12'h0, sel0}, 16'h7);
        check("rmid_data", {15'h0, ser_data0}, 16'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmid_valid", {15'h0, ser_valid0}, 16'h0);
        check("rmid_in_ready", {15'h0, in_ready0}, 16'h1);
        check("rmid_sel", {12'h0, sel0}, 16'h0);
        check("rmid_data0", {15'h0, ser_data0}, 16'h0);
        check("rmid_last", {15'h0, ser_last0}, 16'h0);
        tick();
        check("rmid_no_beat", {15'h0, ser_valid0}, 16'h0);
        run_word0(16'h0001, 1'b1, -1, 0, 1'b0, 16'h0, "after_rst");

        // Reset wins over a simultaneous accept
        in_valid0 = 1'b1;
        in_data0  = 16'hFFFF;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid0 = 1'b0;
        check("rprio_in_ready", {15'h0, in_ready0}, 16'h1);
        check("rprio_valid", {15'h0, ser_valid0}, 16'h0);

        // Back-to-back with in_valid held: exactly one idle cycle between words
        run_word0(16'h1234, 1'b1, -1, 0, 1'b1, 16'h5678, "w1");
        run_word0(16'h5678, 1'b0, -1, 0, 1'b0, 16'h0, "w2");

`ifdef SERIALIZER16_PARITY_EN
        run_word0(16'h0007, 1'b1, -1, 0, 1'b0, 16'h0, "par7");
        run_word0(16'h0003, 1'b0, -1, 0, 1'b0, 16'h0, "par3");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serializer16.md
SERIALIZER16 -- requirements
Module: serializer16

Interface
REQ-001 Parameter: MSB_FIRST, default 0, 0 = bit 0 sent first, 1 = bit 15 sent first.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_data  input  16  parallel word to serialize.
REQ-005 in_valid  input  1  in_data is valid.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 ser_data  output  1  current serial bit.
REQ-008 ser_valid  output  1  ser_data is valid.
REQ-009 ser_ready  input  1  downstream accepts ser_data this cycle.
REQ-010 ser_last  output  1  current beat is the final beat of the word.
REQ-011 sel  output  4  bit index currently presented on ser_data.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and, when the parity feature is compiled in, PARITY.
REQ-013 In IDLE: in_ready=1, ser_valid=0; all other states: in_ready=0, ser_valid=1.
REQ-014 Accept = in_valid && in_ready; on accept, in_data SHALL be latched into a 16-bit holding register, sel SHALL load 0 (MSB_FIRST=0) or 15 (MSB_FIRST=1), and state SHALL go to SHIFT.
REQ-015 In SHIFT, ser_data SHALL equal hold[sel], selected combinationally through the 16:1 mux, with zero-cycle latency from sel.
REQ-016 Beat transfer = ser_valid && ser_ready; sel, ser_data and state SHALL hold while ser_ready=0.
REQ-017 On a beat transfer in SHIFT that is not the final bit, sel SHALL increment (MSB_FIRST=0) or decrement (MSB_FIRST=1) by 1, without wrap.
REQ-018 Final bit = sel==15 (MSB_FIRST=0) or sel==0 (MSB_FIRST=1); a beat transfer on it SHALL go to IDLE (parity off) or PARITY (parity on).
REQ-019 ser_last SHALL be 1 only on the final beat: final bit of SHIFT with parity off, PARITY state with parity on.
REQ-020 Throughput: a word occupies 16 (17 with parity) transfer cycles, plus one IDLE cycle before the next accept. Back-to-back words SHALL have exactly one bubble.
REQ-021 in_valid is ignored outside IDLE; in_data changes after accept SHALL NOT affect the word in flight.

Reset
REQ-022 When rst=1 at a clock edge: state=IDLE, sel=0, hold=0, in_ready=1 after the edge, ser_valid=0, ser_last=0, ser_data=0.
REQ-023 Reset asserted mid-word SHALL discard the word in flight. No further beats of it SHALL appear.
REQ-024 Reset SHALL take priority over a simultaneous accept or beat transfer.

Configuration
REQ-025 Macro SERIALIZER16_PARITY_EN: when defined, after the 16 data beats one PARITY beat SHALL be sent with ser_data = XOR of all 16 held bits (even parity), then IDLE.
REQ-026 Without SERIALIZER16_PARITY_EN, the PARITY state and its logic SHALL NOT exist, and the word ends after 16 beats.

Structure
REQ-027 The shared package SHALL hold the state enum typedef (IDLE/SHIFT/PARITY) and the constants WORD_W=16 and SEL_W=4.
REQ-028 Bit selection SHALL use one instance of the existing mux16_1 sub-module (in=hold, select=sel, y=ser_data source).
REQ-029 The counter and FSM SHALL stay in serializer16, with no other sub-modules.

Verification
REQ-030 MSB_FIRST=0, in_data=16'hA5C3, ser_ready=1 throughout -> ser_data sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; ser_last on beat 16 only; in_ready returns high the cycle after.
REQ-031 MSB_FIRST=1, in_data=16'h8001 -> ser_data 1, fourteen 0s, 1; sel runs 15 down to 0.
REQ-032 Backpressure: ser_ready=0 for 3 cycles at sel=5 -> sel, ser_data and ser_valid hold; resume at sel=6 with no lost or duplicated bit.
REQ-033 rst pulsed at sel=7 of 16'hFFFF -> next cycle ser_valid=0, in_ready=1; next word 16'h0001 serializes cleanly.
REQ-034 Two words 16'h1234 then 16'h5678 with in_valid held high -> exactly one bubble between word 1 ser_last and word 2 first beat.
REQ-035 SERIALIZER16_PARITY_EN defined, in_data=16'h0007 -> 17th beat ser_data=1 with ser_last=1; in_data=16'h0003 -> 17th beat ser_data=0.
